instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- Front-end stage directly upstream of the core's decode input; drives instruction_valid / instruction_ready / instruction.
- Holds the program counter and issues word-aligned read requests to instruction memory.
- Buffers in-order memory responses in a small FIFO.
- Accepts a redirect (branch target) that discards stale in-flight words before fetching resumes at the new PC.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value after reset; bits 30:31 must be 0.
- FETCH_DEPTH, 4, instruction FIFO entries; power of two, >= 2.
- MAX_OUTSTANDING, 4, max in-flight memory requests; must be <= FETCH_DEPTH.

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- fetch_enable  in  1  1 = fetching allowed
- redirect_valid  in  1  load new PC, flush buffered/in-flight words
- redirect_target  in  [0:31]  new PC; bits 30:31 ignored (forced 0)
- mem_req_valid  out  1  read request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  [0:31]  word address (byte address, bits 30:31 = 0)
- mem_resp_valid  in  1  response data valid; always accepted, in request order
- mem_resp_data  in  [0:31]  instruction word, big-endian bit 0 = MSB
- instruction_valid  out  1  FIFO head valid
- instruction_ready  in  1  downstream consumes head
- instruction  out  [0:31]  FIFO head word
- instruction_addr  out  [0:31]  PC of FIFO head word

Behaviour:
- Reset (rst low, async):
  - PC = RESET_VECTOR; FIFO empty; outstanding = 0; discard = 0; state = IDLE.
  - mem_req_valid = 0, mem_req_addr = RESET_VECTOR, instruction_valid = 0, instruction = 0, instruction_addr = 0.
- States:
  - IDLE: no requests. Go to FETCH when fetch_enable = 1.
  - FETCH: mem_req_valid = 1 iff fetch_enable & (outstanding + fifo_count < FETCH_DEPTH) & (outstanding < MAX_OUTSTANDING). mem_req_addr = PC. On request handshake, PC += 4 (wraps modulo 2^32) and outstanding increments. Go to IDLE when fetch_enable = 0; outstanding responses still land in the FIFO.
  - DRAIN: entered on redirect while discard > 0 after the update. mem_req_valid = 0. Each mem_resp_valid decrements discard and the data is dropped. At discard = 0, go to FETCH (or IDLE if fetch_enable = 0).
- Redirect (any state):
  - Same cycle: FIFO cleared and PC = redirect_target & ~3.
  - discard = outstanding, minus 1 if mem_resp_valid is high that cycle; that response is dropped.
  - A request handshaking in the redirect cycle is suppressed: mem_req_valid is masked combinationally by redirect_valid.
  - A downstream pop in the redirect cycle is ignored.
  - If discard = 0 after the update, go directly to FETCH/IDLE.
- Response path:
  - In FETCH/IDLE, a response pushes {data, addr} into the FIFO; addr comes from a response-PC counter that advances by 4 per accepted response.
  - Overflow cannot occur (credit rule); an overflow is an assertion failure.
- FIFO:
  - Registered storage; instruction_valid = (count != 0), head shown combinationally.
  - Latency: response at cycle N is visible at the output in cycle N+1.
  - Simultaneous push and pop when full or empty is legal; count is unchanged when both occur.
  - Pointers wrap modulo FETCH_DEPTH.
- Outstanding counter: simultaneous request and response leaves it unchanged.
- fetch_enable deassertion mid-flight does not drop data.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- Defined: adds output ports stall_cycles [0:31] and redirect_count [0:31]. Both reset to 0 and saturate at all-ones.
  - stall_cycles increments when instruction_ready & ~instruction_valid & fetch_enable.
  - redirect_count increments per redirect_valid cycle.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- ppc_types gains fetch_entry_t (struct: instruction [0:31], addr [0:31]) and fetch_state_t (enum IDLE, FETCH, DRAIN).
- Sub-module fetch_fifo (parameter DEPTH, element fetch_entry_t, with synchronous flush input) holds the buffer; the FSM, PC and counters live in instruction_fetch.

Test Plan:
- Reset release, fetch_enable = 1, mem_req_ready = 1, 1-cycle response memory returning addr^32'hFFFF_0000 -> requests at 0,4,8,12; instructions appear in order with instruction_addr 0,4,8.
- instruction_ready = 0 held -> exactly 4 requests issued (FETCH_DEPTH), FIFO full, mem_req_valid = 0; one pop -> exactly one new request.
- 3 requests outstanding, redirect_valid to 0x100 -> FSM enters DRAIN, the 3 stale responses are dropped, next request address = 0x100, first output instruction_addr = 0x100.
- Redirect to 0x203 with a response arriving the same cycle -> that response is dropped, PC = 0x200, and discard counts only the remaining in-flight requests.
- PC = 0xFFFF_FFFC fetch -> next request address 0x0000_0000.
- rst asserted mid-DRAIN with words buffered -> outputs return to reset values immediately; after release, fetch resumes at RESET_VECTOR.

Source files
------------

// File: rtl/ppc_types.sv
// Shared fetch-path types: buffered instruction entry and fetch FSM states.
package ppc_types;

  typedef struct packed {
    logic [0:31] instruction;
    logic [0:31] addr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fetch_state_t;

  localparam logic [0:31] WORD_MASK = 32'hFFFF_FFFC;

  function automatic logic [0:31] word_align(input logic [0:31] a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: power-of-two circular buffer of fetch entries with synchronous flush.
// Head is shown combinationally and reads as zero when empty.
module fetch_fifo
  import ppc_types::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t        mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                full, do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  // A pop frees the slot in the same cycle, so push-on-full is legal with pop.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, request credit, redirect/drain FSM and response buffering.
// Optional FETCH_PERF_COUNTERS_EN adds stall_cycles / redirect_count outputs.
module instruction_fetch
  import ppc_types::*;
#(
  parameter logic [0:31] RESET_VECTOR    = 32'h0000_0000,
  parameter int          FETCH_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_enable,
  input  logic        redirect_valid,
  input  logic [0:31] redirect_target,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [0:31] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [0:31] mem_resp_data,
  output logic        instruction_valid,
  input  logic        instruction_ready,
  output logic [0:31] instruction,
  output logic [0:31] instruction_addr
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [0:31] stall_cycles,
  output logic [0:31] redirect_count
`endif
);

  localparam int          CW      = $clog2(FETCH_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FETCH_DEPTH);
  localparam logic [CW-1:0] MAX_L = CW'(MAX_OUTSTANDING);

  fetch_state_t  state;
  logic [0:31]   pc, resp_pc;
  logic [CW-1:0] outstanding, outstanding_nxt, discard, discard_redir, fifo_count;
  logic          fifo_empty, can_issue, req_fire, push, pop;
  fetch_entry_t  head, push_entry;

  // Credit: every in-flight request must have a FIFO slot reserved for it.
  assign can_issue = fetch_enable
                  && (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_L)
                  && (outstanding < MAX_L);
  assign mem_req_valid = (state == FETCH) && can_issue && !redirect_valid;
  assign mem_req_addr  = pc;
  assign req_fire      = mem_req_valid && mem_req_ready;

  assign push = mem_resp_valid && !redirect_valid && (state != DRAIN);
  assign pop  = instruction_ready && instruction_valid && !redirect_valid;
  assign push_entry = '{instruction: mem_resp_data, addr: resp_pc};

  assign discard_redir = mem_resp_valid ? outstanding - CW'(1) : outstanding;

  always_comb begin
    outstanding_nxt = outstanding;
    case ({req_fire, mem_resp_valid})
      2'b10:   outstanding_nxt = outstanding + CW'(1);
      2'b01:   outstanding_nxt = outstanding - CW'(1);
      default: outstanding_nxt = outstanding;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        pc      <= word_align(redirect_target);
        resp_pc <= word_align(redirect_target);
        discard <= discard_redir;
        if (discard_redir != '0) state <= DRAIN;
        else                     state <= fetch_enable ? FETCH : IDLE;
      end else begin
        if (req_fire) pc      <= pc + 32'd4;
        if (push)     resp_pc <= resp_pc + 32'd4;
        case (state)
          IDLE:  if (fetch_enable) state <= FETCH;
          FETCH: if (!fetch_enable) state <= IDLE;
          DRAIN: if (mem_resp_valid) begin
            discard <= discard - CW'(1);
            if (discard == CW'(1)) state <= fetch_enable ? FETCH : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  fetch_fifo #(.DEPTH(FETCH_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign instruction_valid = !fifo_empty;
  assign instruction       = head.instruction;
  assign instruction_addr  = head.addr;

`ifdef FETCH_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles   <= '0;
      redirect_count <= '0;
    end else begin
      if (instruction_ready && !instruction_valid && fetch_enable && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (redirect_valid && (redirect_count != '1))
        redirect_count <= redirect_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: in-order fetch, credit stall, redirect drain,
// PC wrap and async reset, against a queue-based memory with optional response hold.
module tb_instruction_fetch;

  logic        clk, rst;
  logic        fetch_enable, redirect_valid;
  logic [0:31] redirect_target;
  logic        mem_req_valid, mem_req_ready;
  logic [0:31] mem_req_addr;
  logic        mem_resp_valid;
  logic [0:31] mem_resp_data;
  logic        instruction_valid, instruction_ready;
  logic [0:31] instruction, instruction_addr;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [0:31] stall_cycles, redirect_count;
`endif

  instruction_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_enable      (fetch_enable),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .mem_req_valid     (mem_req_valid),
    .mem_req_ready     (mem_req_ready),
    .mem_req_addr      (mem_req_addr),
    .mem_resp_valid    (mem_resp_valid),
    .mem_resp_data     (mem_resp_data),
    .instruction_valid (instruction_valid),
    .instruction_ready (instruction_ready),
    .instruction       (instruction),
    .instruction_addr  (instruction_addr)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .stall_cycles      (stall_cycles),
    .redirect_count    (redirect_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic hold;
  logic [31:0] pend[$];
  logic [31:0] req_log[$];
  logic [31:0] pop_addr[$];
  logic [31:0] pop_data[$];

  localparam logic [31:0] XMASK = 32'hFFFF_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic drive_resp();
    if (!hold && pend.size() > 0) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = pend.pop_front() ^ XMASK;
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
  endtask

  // One clock: sample handshakes before the edge, then drive the next response.
  task automatic tick();
    logic fire, popv;
    logic [31:0] a, pa, pd;
    #1;
    fire = mem_req_valid && mem_req_ready;
    a    = mem_req_addr;
    popv = instruction_valid && instruction_ready && !redirect_valid;
    pa   = instruction_addr;
    pd   = instruction;
    @(posedge clk);
    @(negedge clk);
    if (fire) begin
      pend.push_back(a);
      req_log.push_back(a);
    end
    if (popv) begin
      pop_addr.push_back(pa);
      pop_data.push_back(pd);
    end
    drive_resp();
  endtask

  task automatic clear_logs();
    req_log.delete();
    pop_addr.delete();
    pop_data.delete();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    fetch_enable = 1'b1;
    redirect_valid = 1'b0;
    redirect_target = '0;
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    instruction_ready = 1'b1;
    hold = 1'b0;
    pend.delete();
    clear_logs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1);
  end

  initial begin
    // Reset values
    rst = 1'b0;
    do_reset();
    rst = 1'b0;
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_instr_valid", 32'(instruction_valid), 0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_instr_addr", instruction_addr, 32'h0);

    // In-order fetch with 1-cycle memory
    do_reset();
    repeat (10) tick();
    chk("t1_req0", at(req_log, 0), 32'h0);
    chk("t1_req1", at(req_log, 1), 32'h4);
    chk("t1_req2", at(req_log, 2), 32'h8);
    chk("t1_req3", at(req_log, 3), 32'hC);
    chk("t1_pop0_addr", at(pop_addr, 0), 32'h0);
    chk("t1_pop1_addr", at(pop_addr, 1), 32'h4);
    chk("t1_pop2_addr", at(pop_addr, 2), 32'h8);
    chk("t1_pop0_data", at(pop_data, 0), 32'hFFFF_0000);
    chk("t1_pop2_data", at(pop_data, 2), 32'hFFFF_0008);

    // Credit stall: FIFO fills, then one pop releases one request
    do_reset();
    instruction_ready = 1'b0;
    repeat (12) tick();
    chk("t2_req_count", req_log.size(), 4);
    chk("t2_full_noreq", 32'(mem_req_valid), 0);
    chk("t2_head_valid", 32'(instruction_valid), 1);
    chk("t2_head_addr", instruction_addr, 32'h0);
    instruction_ready = 1'b1;
    tick();
    instruction_ready = 1'b0;
    repeat (8) tick();
    chk("t2_req_after_pop", req_log.size(), 5);
    chk("t2_req4_addr", at(req_log, 4), 32'h10);
    chk("t2_head_after_pop", instruction_addr, 32'h4);

    // Redirect with three requests in flight
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 10 && req_log.size() < 3; i++) tick();
    mem_req_ready = 1'b0;
    chk("t3_inflight", req_log.size(), 3);
    redirect_valid = 1'b1;
    redirect_target = 32'h100;
    tick();
    redirect_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    chk("t3_drain_noreq", 32'(mem_req_valid), 0);
    chk("t3_pc", mem_req_addr, 32'h100);
    hold = 1'b0;
    drive_resp();
    clear_logs();
    repeat (3) tick();
    chk("t3_no_req_in_drain", req_log.size(), 0);
    repeat (6) tick();
    chk("t3_first_req", at(req_log, 0), 32'h100);
    chk("t3_first_pop_addr", at(pop_addr, 0), 32'h100);
    chk("t3_first_pop_data", at(pop_data, 0), 32'hFFFF_0100);

    // Redirect to unaligned target with a response in the same cycle
    do_reset();
    hold = 1'b1;
    for (int i = 0; i < 10 && req_log.size() < 3; i++) tick();
    mem_req_ready = 1'b0;
    hold = 1'b0;
    drive_resp();
    redirect_valid = 1'b1;
    redirect_target = 32'h203;
    tick();
    redirect_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1;
    chk("t4_pc_aligned", mem_req_addr, 32'h200);
    chk("t4_drain_noreq", 32'(mem_req_valid), 0);
    clear_logs();
    repeat (2) tick();
    chk("t4_drain_len", req_log.size(), 0);
    tick();
    chk("t4_resume", req_log.size(), 1);
    chk("t4_first_req", at(req_log, 0), 32'h200);
    repeat (4) tick();
    chk("t4_first_pop_addr", at(pop_addr, 0), 32'h200);

    // PC wrap
    do_reset();
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    repeat (6) tick();
    chk("t5_req0", at(req_log, 0), 32'hFFFF_FFFC);
    chk("t5_req1_wrap", at(req_log, 1), 32'h0);
    chk("t5_pop0_data", at(pop_data, 0), 32'h0000_FFFC);
    chk("t5_pop1_addr", at(pop_addr, 1), 32'h0);

    // Async reset mid-DRAIN
    do_reset();
    instruction_ready = 1'b0;
    repeat (3) tick();
    hold = 1'b1;
    repeat (2) tick();
    chk("t6_buffered", 32'(instruction_valid), 1);
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t6_drain_pc", mem_req_addr, 32'h40);
    chk("t6_drain_noreq", 32'(mem_req_valid), 0);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_addr", mem_req_addr, 32'h0);
    chk("t6_rst_req_valid", 32'(mem_req_valid), 0);
    chk("t6_rst_instr_valid", 32'(instruction_valid), 0);
    chk("t6_rst_instr_addr", instruction_addr, 32'h0);
    pend.delete();
    hold = 1'b0;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    clear_logs();
    instruction_ready = 1'b1;
    repeat (8) tick();
    chk("t6_resume_req0", at(req_log, 0), 32'h0);
    chk("t6_resume_req1", at(req_log, 1), 32'h4);
    chk("t6_resume_pop0", at(pop_addr, 0), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
